// File: rtl/mem_arb_pipeline.sv
// mem_arb_pipeline: two-master (IFU/LSU) arbiter for the single-outstanding
// memory port. LSU has fixed priority; responses are routed back to the owner
// and discarded when the owner was flushed while its transaction was in flight.
// Optional feature: define MEM_ARB_TIMEOUT_EN to force-complete a transaction
// after TIMEOUT busy cycles without a memory response.
module mem_arb_pipeline #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    input  logic        ifu_flush,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    input  logic        lsu_flush,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        arb_timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic        owner;
    logic        drop;

    logic        ifu_pend;
    logic [31:0] ifu_pend_addr;
    logic        lsu_pend;
    logic        lsu_pend_wen;
    logic [31:0] lsu_pend_addr;
    logic [31:0] lsu_pend_wdata;
    logic [3:0]  lsu_pend_wmask;

    logic        timeout_fire;
    logic        done;
    logic        can_grant;
    logic        ifu_live;
    logic        lsu_live;
    logic        grant_ifu;
    logic        grant_lsu;
    logic        resp_valid;
    logic [31:0] resp_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_V = 10'(TIMEOUT);
    logic [9:0] wait_cnt;

    // Wait counter: restarts at every grant and counts each cycle spent busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (grant_ifu || grant_lsu) begin
            wait_cnt <= '0;
        end else if (state == BUSY) begin
            wait_cnt <= wait_cnt + 10'd1;
        end
    end

    // A real response in the expiry cycle wins over the forced completion
    assign timeout_fire = (state == BUSY) && (wait_cnt == TIMEOUT_V) && !mem_rvalid;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_fire   = 1'b0;
`endif

    // Grant decision: a grant can be made when idle or in the cycle the current
    // transaction completes, so the next mem_req follows the response directly
    always_comb begin
        done       = (state == BUSY) && (mem_rvalid || timeout_fire);
        can_grant  = (state == IDLE) || done;
        lsu_live   = (lsu_pend || lsu_req) && !lsu_flush;
        ifu_live   = (ifu_pend || ifu_req) && !ifu_flush;
        grant_lsu  = can_grant && lsu_live;
        grant_ifu  = can_grant && ifu_live && !lsu_live;
        resp_valid = done && !drop;
        resp_data  = mem_rvalid ? mem_rdata : 32'hDEADBEEF;
    end

    assign ifu_rvalid  = resp_valid && !owner;
    assign lsu_rvalid  = resp_valid && owner;
    assign ifu_rdata   = ifu_rvalid ? resp_data : 32'h0;
    assign lsu_rdata   = lsu_rvalid ? resp_data : 32'h0;
    assign arb_timeout = timeout_fire;

    // Pending slots: a granted slot empties, a new pulse (even alongside a
    // flush) is kept as the post-redirect request, a bare flush discards it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_pend       <= 1'b0;
            ifu_pend_addr  <= '0;
            lsu_pend       <= 1'b0;
            lsu_pend_wen   <= 1'b0;
            lsu_pend_addr  <= '0;
            lsu_pend_wdata <= '0;
            lsu_pend_wmask <= '0;
        end else begin
            if (grant_ifu) begin
                ifu_pend <= 1'b0;
            end else if (ifu_req) begin
                ifu_pend      <= 1'b1;
                ifu_pend_addr <= ifu_addr;
            end else if (ifu_flush) begin
                ifu_pend <= 1'b0;
            end
            if (grant_lsu) begin
                lsu_pend <= 1'b0;
            end else if (lsu_req) begin
                lsu_pend       <= 1'b1;
                lsu_pend_wen   <= lsu_wen;
                lsu_pend_addr  <= lsu_addr;
                lsu_pend_wdata <= lsu_wdata;
                lsu_pend_wmask <= lsu_wmask;
            end else if (lsu_flush) begin
                lsu_pend <= 1'b0;
            end
        end
    end

    // Arbiter FSM: issues the registered memory command, tracks owner and drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            drop      <= 1'b0;
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            mem_req <= 1'b0;
            if (grant_lsu) begin
                state     <= BUSY;
                owner     <= 1'b1;
                drop      <= 1'b0;
                mem_req   <= 1'b1;
                mem_wen   <= lsu_req ? lsu_wen   : lsu_pend_wen;
                mem_addr  <= lsu_req ? lsu_addr  : lsu_pend_addr;
                mem_wdata <= lsu_req ? lsu_wdata : lsu_pend_wdata;
                mem_wmask <= lsu_req ? lsu_wmask : lsu_pend_wmask;
            end else if (grant_ifu) begin
                state     <= BUSY;
                owner     <= 1'b0;
                drop      <= 1'b0;
                mem_req   <= 1'b1;
                mem_wen   <= 1'b0;
                mem_addr  <= ifu_req ? ifu_addr : ifu_pend_addr;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end else if (done) begin
                state <= IDLE;
                drop  <= 1'b0;
            end else if (state == BUSY && ((owner && lsu_flush) || (!owner && ifu_flush))) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb_pipeline.sv
// Directed testbench for mem_arb_pipeline. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_mem_arb_pipeline;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_flush = 1'b0;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_flush = 1'b0;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        arb_timeout;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_pipeline #(.TIMEOUT(16)) dut (
`else
    mem_arb_pipeline dut (
`endif
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_flush(ifu_flush),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_flush(lsu_flush),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .arb_timeout(arb_timeout)
    );

    // The two response pulses must never coincide
    always @(negedge clk) begin
        if (!rst) begin
            compared++;
            if ((ifu_rvalid && lsu_rvalid) !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rvalid_exclusive: ifu=%b lsu=%b required not both 1", ifu_rvalid, lsu_rvalid);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick;
        settle;
        compared++;
        if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_req: got %b need 0", mem_req); end
        compared++;
        if (mem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h need 0", mem_addr); end
        compared++;
        if ({ifu_rvalid, lsu_rvalid, arb_timeout} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_pulses: got %b need 000", {ifu_rvalid, lsu_rvalid, arb_timeout}); end
        tick;
        rst = 1'b0;
        settle;
    endtask

    task automatic test_single_ifu;
        tick;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
        tick;
        ifu_req = 1'b0;
        settle;
        compared++;
        if ({mem_req, mem_wen} !== 2'b10) begin mismatched++; $display("[TB] FAIL ifu_issue: req/wen got %b need 10", {mem_req, mem_wen}); end
        compared++;
        if (mem_addr !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL ifu_addr: got %h need 80000000", mem_addr); end
        tick;
        settle;
        compared++;
        if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL ifu_req_pulse: got %b need 0", mem_req); end
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
        settle;
        compared++;
        if ({ifu_rvalid, lsu_rvalid} !== 2'b10) begin mismatched++; $display("[TB] FAIL ifu_resp: ifu/lsu got %b need 10", {ifu_rvalid, lsu_rvalid}); end
        compared++;
        if (ifu_rdata !== 32'h0000_0413) begin mismatched++; $display("[TB] FAIL ifu_rdata: got %h need 00000413", ifu_rdata); end
        tick;
        mem_rvalid = 1'b0;
        settle;
        compared++;
        if ({ifu_rvalid, mem_req} !== 2'b00) begin mismatched++; $display("[TB] FAIL ifu_quiet: rvalid/req got %b need 00", {ifu_rvalid, mem_req}); end
    endtask

    task automatic test_conflict;
        tick;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h0F00_0010;
        lsu_wdata = 32'h0000_00AB; lsu_wmask = 4'b0001;
        tick;
        ifu_req = 1'b0; lsu_req = 1'b0;
        settle;
        compared++;
        if ({mem_req, mem_wen, mem_addr} !== {2'b11, 32'h0F00_0010}) begin mismatched++; $display("[TB] FAIL conflict_lsu_first: req/wen/addr got %b%b %h need 11 0f000010", mem_req, mem_wen, mem_addr); end
        compared++;
        if ({mem_wdata, mem_wmask} !== {32'h0000_00AB, 4'b0001}) begin mismatched++; $display("[TB] FAIL conflict_wfields: got %h/%b need 000000ab/0001", mem_wdata, mem_wmask); end
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
        settle;
        compared++;
        if ({lsu_rvalid, ifu_rvalid, lsu_rdata} !== {2'b10, 32'h0000_1234}) begin mismatched++; $display("[TB] FAIL conflict_lsu_resp: lsu/ifu/data got %b%b %h need 10 00001234", lsu_rvalid, ifu_rvalid, lsu_rdata); end
        tick;
        mem_rvalid = 1'b0;
        settle;
        compared++;
        if ({mem_req, mem_wen, mem_addr} !== {2'b10, 32'h8000_0004}) begin mismatched++; $display("[TB] FAIL conflict_ifu_next: req/wen/addr got %b%b %h need 10 80000004", mem_req, mem_wen, mem_addr); end
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_5555;
        settle;
        compared++;
        if ({ifu_rvalid, ifu_rdata} !== {1'b1, 32'h0000_5555}) begin mismatched++; $display("[TB] FAIL conflict_ifu_resp: got %b %h need 1 00005555", ifu_rvalid, ifu_rdata); end
        tick;
        mem_rvalid = 1'b0;
        settle;
    endtask

    task automatic test_inflight_flush;
        tick;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0008;
        tick;
        ifu_req = 1'b0;
        settle;
        compared++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h8000_0008}) begin mismatched++; $display("[TB] FAIL flush_first_issue: got %b %h need 1 80000008", mem_req, mem_addr); end
        tick;
        ifu_flush = 1'b1; ifu_req = 1'b1; ifu_addr = 32'h8000_0100;
        tick;
        ifu_flush = 1'b0; ifu_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_1111;
        settle;
        compared++;
        if (ifu_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_dropped: ifu_rvalid got %b need 0", ifu_rvalid); end
        tick;
        mem_rvalid = 1'b0;
        settle;
        compared++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h8000_0100}) begin mismatched++; $display("[TB] FAIL flush_redirect_issue: got %b %h need 1 80000100", mem_req, mem_addr); end
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_2222;
        settle;
        compared++;
        if ({ifu_rvalid, ifu_rdata} !== {1'b1, 32'h0000_2222}) begin mismatched++; $display("[TB] FAIL flush_redirect_resp: got %b %h need 1 00002222", ifu_rvalid, ifu_rdata); end
        tick;
        mem_rvalid = 1'b0;
        settle;
        compared++;
        if ({ifu_rvalid, mem_req} !== 2'b00) begin mismatched++; $display("[TB] FAIL flush_single_resp: rvalid/req got %b need 00", {ifu_rvalid, mem_req}); end
    endtask

    task automatic test_pending_flush;
        tick;
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_0100;
        tick;
        lsu_req = 1'b0;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0200;
        settle;
        compared++;
        if ({mem_req, mem_wen, mem_addr} !== {2'b10, 32'h0000_0100}) begin mismatched++; $display("[TB] FAIL pend_lsu_issue: got %b%b %h need 10 00000100", mem_req, mem_wen, mem_addr); end
        tick;
        ifu_req = 1'b0; ifu_flush = 1'b1;
        tick;
        ifu_flush = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_3333;
        settle;
        compared++;
        if ({lsu_rvalid, lsu_rdata} !== {1'b1, 32'h0000_3333}) begin mismatched++; $display("[TB] FAIL pend_lsu_resp: got %b %h need 1 00003333", lsu_rvalid, lsu_rdata); end
        for (int i = 0; i < 2; i++) begin
            tick;
            mem_rvalid = 1'b0;
            settle;
            compared++;
            if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL pend_no_ifu_issue: cycle %0d mem_req got %b need 0", i, mem_req); end
        end
    endtask

    task automatic test_reset_midway;
        tick;
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_0200;
        tick;
        lsu_req = 1'b0;
        settle;
        compared++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0200}) begin mismatched++; $display("[TB] FAIL rstmid_issue: got %b %h need 1 00000200", mem_req, mem_addr); end
        tick;
        rst = 1'b1;
        settle;
        compared++;
        if ({mem_req, mem_addr} !== {1'b0, 32'h0}) begin mismatched++; $display("[TB] FAIL rstmid_cleared: got %b %h need 0 00000000", mem_req, mem_addr); end
        tick;
        rst = 1'b0;
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_9999;
        settle;
        compared++;
        if ({ifu_rvalid, lsu_rvalid} !== 2'b00) begin mismatched++; $display("[TB] FAIL rstmid_stray: ifu/lsu got %b need 00", {ifu_rvalid, lsu_rvalid}); end
        tick;
        mem_rvalid = 1'b0;
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h0000_0300;
        lsu_wdata = 32'h0000_0077; lsu_wmask = 4'hF;
        tick;
        lsu_req = 1'b0;
        settle;
        compared++;
        if ({mem_req, mem_wen, mem_addr, mem_wmask} !== {2'b11, 32'h0000_0300, 4'hF}) begin mismatched++; $display("[TB] FAIL rstmid_reissue: got %b%b %h %h need 11 00000300 f", mem_req, mem_wen, mem_addr, mem_wmask); end
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0000;
        settle;
        compared++;
        if (lsu_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_resp: lsu_rvalid got %b need 1", lsu_rvalid); end
        tick;
        mem_rvalid = 1'b0;
        settle;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        tick;
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_0400;
        tick;
        lsu_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            settle;
            compared++;
            if ({lsu_rvalid, arb_timeout} !== 2'b00) begin mismatched++; $display("[TB] FAIL timeout_early: busy cycle %0d got %b need 00", i, {lsu_rvalid, arb_timeout}); end
            tick;
        end
        settle;
        compared++;
        if ({lsu_rvalid, arb_timeout, lsu_rdata} !== {2'b11, 32'hDEADBEEF}) begin mismatched++; $display("[TB] FAIL timeout_fire: got %b%b %h need 11 deadbeef", lsu_rvalid, arb_timeout, lsu_rdata); end
        tick;
        settle;
        compared++;
        if ({arb_timeout, mem_req} !== 2'b00) begin mismatched++; $display("[TB] FAIL timeout_after: got %b need 00", {arb_timeout, mem_req}); end
        tick;
        lsu_req = 1'b1; lsu_addr = 32'h0000_0500;
        tick;
        lsu_req = 1'b0;
        settle;
        compared++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0500}) begin mismatched++; $display("[TB] FAIL timeout_idle_after: got %b %h need 1 00000500", mem_req, mem_addr); end
        tick;
        mem_rvalid = 1'b1;
        tick;
        mem_rvalid = 1'b0;
        settle;
    endtask
`endif

    initial begin
        test_reset;
        test_single_ifu;
        test_conflict;
        test_inflight_flush;
        test_pending_flush;
        test_reset_midway;
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arb_pipeline.md
# mem_arb_pipeline

Two-master memory arbiter that lets the pipeline's instruction fetch unit (IFU) and load/store unit (LSU) share the single-outstanding memory port. Both masters use the pipeline's pulse protocol: one-cycle `req`, and a one-cycle `rvalid` returned for both reads and writes. The block captures request pulses into pending slots and grants the port with fixed LSU priority. It registers the winning command onto the memory side, routes the response back to its owner, and drops responses belonging to a flushed master.

## Interface
- `TIMEOUT`, 1023: cycles to wait for `mem_rvalid` before forcing a response. Used only with `MEM_ARB_TIMEOUT_EN`.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `ifu_req`  in  1  IFU read request pulse
- `ifu_addr`  in  32  IFU fetch address, sampled with `ifu_req`
- `ifu_flush`  in  1  discard IFU pending or in-flight request
- `ifu_rvalid`  out  1  IFU response pulse
- `ifu_rdata`  out  32  IFU response data
- `lsu_req`  in  1  LSU request pulse
- `lsu_wen`  in  1  1 = store, sampled with `lsu_req`
- `lsu_addr`  in  32  sampled with `lsu_req`
- `lsu_wdata`  in  32  sampled with `lsu_req`
- `lsu_wmask`  in  4  sampled with `lsu_req`
- `lsu_flush`  in  1  discard LSU pending or in-flight request
- `lsu_rvalid`  out  1  LSU response pulse
- `lsu_rdata`  out  32  LSU response data
- `mem_req`  out  1  registered one-cycle request to memory
- `mem_wen`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/32/32/4  registered command fields
- `mem_rvalid`  in  1  memory response pulse
- `mem_rdata`  in  32  memory response data
- `arb_timeout`  out  1  one-cycle pulse when a transaction is force-completed

## Operation
- **Pending slots:** `ifu_pend` with its address, and `lsu_pend` with wen/addr/wdata/wmask. A request pulse sets the slot and overwrites its fields. Each master issues at most one request before its `rvalid`; a second pulse while the slot is pending overwrites the slot and counts as one request.
- **States:**
  - IDLE: no transaction in flight.
  - BUSY: one transaction outstanding. An `owner` bit (0 = IFU, 1 = LSU) and a `drop` bit record whom it belongs to and whether its response is discarded.
- **IDLE → BUSY:** taken when a request is live, meaning the slot is pending or a pulse arrives this cycle.
  - Grant goes to the LSU if its request is live, otherwise to the IFU.
  - At the edge: the command loads into the `mem_*` registers, `mem_req`=1, the granted slot clears, `owner` is set, and `drop`=0.
  - A master's own flush in the same cycle cancels its grant; the other master may still be granted.
- **In BUSY:** `mem_req` is 0 after the first cycle and the `mem_*` fields stay stable.
- **BUSY → IDLE:** taken on `mem_rvalid`.
  - If `drop`=0, the owner's `rvalid` is 1 in the same cycle and its `rdata` equals `mem_rdata`, combinationally.
  - If `drop`=1, nothing is signalled.
- **Flush:**
  - A flush of the owner while BUSY sets `drop`.
  - A flush always clears that master's pending slot.
  - A request pulse in the same cycle as that master's flush is retained; it is treated as a post-redirect request and issues after the dropped transaction.
- Store responses return `mem_rdata` unchanged; the LSU ignores it.

## Timing
- **Reset values:** state IDLE; all outputs 0; slots empty; `drop`=0; `owner`=0.
- **Grant latency:** a request pulse in cycle T with the arbiter idle gives `mem_req` in cycle T+1.
- **Response:** `mem_rvalid` in cycle R gives owner `rvalid` in R. The earliest next `mem_req` is R+1.
- **Minimum occupancy:** with a 1-cycle memory (`rvalid` the cycle after `mem_req`), back-to-back service gives one transaction every 2 cycles.
- **Simultaneous requests:** `ifu_req` and `lsu_req` in the same idle cycle → the LSU issues first. The IFU issues in the cycle after the LSU response.
- **Starvation:** continuous LSU traffic may starve the IFU. This is acceptable because the LSU blocks the pipeline until it is served.
- **Mid-operation reset:** returns to reset values immediately. Any late `mem_rvalid` arriving in IDLE is ignored.
- **Bus side:** `ifu_rvalid` and `lsu_rvalid` are never 1 together.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:**
  - A 10-bit wait counter clears on grant and increments every BUSY cycle.
  - When the counter reaches `TIMEOUT` with no `mem_rvalid`, the owner receives `rvalid`=1 with `rdata`=32'hDEADBEEF (unless `drop`). In the same cycle `arb_timeout` pulses and the state returns to IDLE.
  - A `mem_rvalid` arriving in the same cycle as expiry takes precedence: it is a normal response with no timeout pulse.
- **Undefined:** no counter; BUSY waits indefinitely; `arb_timeout` is tied to 0.

## Test plan
- **Single IFU read:** `ifu_req` with addr 0x8000_0000 at T; memory returns 0x00000413 two cycles after `mem_req` → `mem_req`/`mem_addr`=0x8000_0000 at T+1 with `mem_wen`=0, then `ifu_rvalid` with 0x00000413; `lsu_rvalid` stays 0.
- **Same-cycle conflict:** `ifu_req` at 0x8000_0004 and an `lsu_req` store at 0x0F00_0010 (wdata 0xAB, wmask 0001) in the same cycle → the LSU command goes out first; the IFU `mem_req` appears the cycle after `lsu_rvalid`.
- **In-flight flush:** `ifu_flush` while an IFU read is BUSY, plus `ifu_req` at 0x8000_0100 in the same cycle → the old response produces no `ifu_rvalid`; the next `mem_addr` is 0x8000_0100, followed by one `ifu_rvalid`.
- **Pending flush:** IFU request pending behind an LSU load, then `ifu_flush` → only the LSU transaction reaches memory.
- **Reset mid-transaction:** assert `rst` while BUSY, deassert, then a stray `mem_rvalid` arrives → no `rvalid` on either side; the next `lsu_req` issues normally.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=16):** memory never responds to an `lsu_req` → 16 BUSY cycles, then `lsu_rvalid` with 0xDEADBEEF and an `arb_timeout` pulse; the arbiter is IDLE afterwards.
